// File: rtl/seg_scroll_ctrl.sv
// Scrolls a buffered message of up to 16 ASCII characters right-to-left through a 4-digit window.
// o_data is registered (1-cycle latency); writes are refused while scrolling or when the buffer is full.
module seg_scroll_ctrl #(
   parameter int unsigned p_system_clk = 100_000_000,
   parameter int unsigned p_step_ms    = 250
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_wr_valid,
   input  logic [7:0]  i_wr_data,
   output logic        o_wr_ready,
   input  logic        i_clear,
   input  logic        i_start,
   input  logic        i_loop,
   input  logic        i_stop,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_data
);

   localparam logic [31:0] lp_step_last = 32'(p_system_clk / 1000 * p_step_ms - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SCROLL = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [4:0]  r_len, w_len_nxt;
   logic [5:0]  r_s, w_s_nxt;
   logic [31:0] r_tick, w_tick_nxt;
   logic [31:0] r_data, w_data_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic        w_wr_acc, w_wr_en;
   logic [7:0]  r_mem [16];

   assign o_wr_ready = (r_state == ST_IDLE) && (r_len < 5'd16);
   assign w_wr_acc   = i_wr_valid && o_wr_ready;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_data     = r_data;

   // The IDLE preview is the same window evaluated at padded index 4.
   always_comb begin
      logic [5:0] v_idx;
      v_idx      = '0;
      w_data_nxt = '0;
      for (int k = 0; k < 4; k++) begin
         if (r_state == ST_SCROLL) v_idx = r_s + 6'(k);
         else                      v_idx = 6'(k + 4);
         if ((v_idx >= 6'd4) && (v_idx < ({1'b0, r_len} + 6'd4)))
            w_data_nxt[31-8*k -: 8] = r_mem[4'(v_idx - 6'd4)];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_s_nxt     = r_s;
      w_tick_nxt  = r_tick;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_wr_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_clear) begin
               w_len_nxt = '0;
            end else begin
               if (w_wr_acc) begin
                  w_wr_en   = 1'b1;
                  w_len_nxt = r_len + 5'd1;
               end
               if (i_start && ((r_len != 5'd0) || w_wr_acc)) begin
                  w_state_nxt = ST_SCROLL;
                  w_s_nxt     = 6'd1;
                  w_tick_nxt  = '0;
                  w_busy_nxt  = 1'b1;
               end
            end
         end
         ST_SCROLL: begin
            if (i_stop) begin
               w_state_nxt = ST_IDLE;
               w_s_nxt     = '0;
               w_tick_nxt  = '0;
               w_busy_nxt  = 1'b0;
            end else if (r_tick == lp_step_last) begin
               w_tick_nxt = '0;
               if (r_s == ({1'b0, r_len} + 6'd4)) begin
                  if (i_loop) begin
                     w_s_nxt = 6'd1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_s_nxt     = '0;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
                  end
               end else begin
                  w_s_nxt = r_s + 6'd1;
               end
            end else begin
               w_tick_nxt = r_tick + 32'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_len   <= '0;
         r_s     <= '0;
         r_tick  <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_len   <= w_len_nxt;
         r_s     <= w_s_nxt;
         r_tick  <= w_tick_nxt;
         r_data  <= w_data_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Stale contents are harmless: len gates every read.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_len[3:0]] <= i_wr_data;
   end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Bench for seg_scroll_ctrl: directed test-plan scenarios plus randomized traffic
// checked every cycle against a padded-string reference model.
module tb_seg_scroll_ctrl;

   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_wr_valid = 1'b0;
   logic [7:0]  i_wr_data = 8'h00;
   logic        o_wr_ready;
   logic        i_clear = 1'b0;
   logic        i_start = 1'b0;
   logic        i_loop = 1'b0;
   logic        i_stop = 1'b0;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_data;

   always #5 clk = ~clk;

   seg_scroll_ctrl #(.p_system_clk(4000), .p_step_ms(1)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_wr_valid (i_wr_valid),
      .i_wr_data  (i_wr_data),
      .o_wr_ready (o_wr_ready),
      .i_clear    (i_clear),
      .i_start    (i_start),
      .i_loop     (i_loop),
      .i_stop     (i_stop),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_data     (o_data)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: message as a queue, scroll position as cycles since pass start.
   byte unsigned m_msg[$];
   bit           m_scroll;
   int           m_pass;
   logic [31:0]  m_data;
   bit           m_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] pchar(input int i);
      if (i >= 4 && (i - 4) < m_msg.size()) return m_msg[i-4];
      return 8'h00;
   endfunction

   function automatic logic [31:0] window(input int s);
      return {pchar(s), pchar(s + 1), pchar(s + 2), pchar(s + 3)};
   endfunction

   task automatic model_reset();
      m_msg.delete();
      m_scroll = 1'b0;
      m_pass   = 0;
      m_data   = 32'h0;
      m_done   = 1'b0;
   endtask

   // One clock: predict from current inputs, advance, then compare all outputs.
   task automatic cyc();
      logic [31:0] nd;
      bit          rdy;
      rdy = !m_scroll && (m_msg.size() < 16);
      chk("wr_ready", 32'(o_wr_ready), 32'(rdy));
      nd = m_scroll ? window(1 + m_pass / STEP) : window(4);
      m_done = 1'b0;
      if (!m_scroll) begin
         if (i_clear) begin
            m_msg.delete();
         end else begin
            if (i_wr_valid && rdy) m_msg.push_back(i_wr_data);
            if (i_start && m_msg.size() > 0) begin
               m_scroll = 1'b1;
               m_pass   = 0;
            end
         end
      end else if (i_stop) begin
         m_scroll = 1'b0;
      end else if (m_pass == STEP * (m_msg.size() + 4) - 1) begin
         if (i_loop) m_pass = 0;
         else begin
            m_scroll = 1'b0;
            m_done   = 1'b1;
         end
      end else begin
         m_pass++;
      end
      m_data = nd;
      @(posedge clk);
      #1;
      chk("data", o_data, m_data);
      chk("busy", 32'(o_busy), 32'(m_scroll));
      chk("done", 32'(o_done), 32'(m_done));
   endtask

   task automatic put(input logic [7:0] c);
      i_wr_valid = 1'b1;
      i_wr_data  = c;
      cyc();
      i_wr_valid = 1'b0;
   endtask

   task automatic async_reset();
      #3 rstn = 1'b0;
      #1;
      chk("rst_data", o_data, 32'h0);
      chk("rst_ready", 32'(o_wr_ready), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   initial begin
      logic [31:0] frames [8];
      string       cap;
      int          done_at;
      int          hs;

      frames = '{32'h00000031, 32'h00003132, 32'h00313241, 32'h31324142,
                 32'h32414200, 32'h41420000, 32'h42000000, 32'h00000000};
      cap = "0123456789ABCDEFX";
      model_reset();

      @(posedge clk);
      #1;
      chk("init_data", o_data, 32'h0);
      chk("init_ready", 32'(o_wr_ready), 32'd1);
      chk("init_busy", 32'(o_busy), 32'd0);
      chk("init_done", 32'(o_done), 32'd0);
      rstn = 1'b1;
      cyc();

      // Basic scroll of "12AB"
      put("1"); put("2"); put("A"); put("B");
      cyc();
      chk("preview_12AB", o_data, 32'h31324142);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      done_at = -1;
      for (int i = 1; i <= 34; i++) begin
         cyc();
         if ((i % 4) == 1 && i <= 29) chk("frame", o_data, frames[(i-1)/4]);
         if (o_done && done_at < 0) done_at = i;
         if (i == 33) chk("preview_back", o_data, 32'h31324142);
      end
      chk("done_latency", 32'(done_at), 32'd32);

      // Capacity: 17 back-to-back writes
      i_clear = 1'b1;
      cyc();
      i_clear = 1'b0;
      hs = 0;
      i_wr_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         i_wr_data = cap[i];
         if (o_wr_ready) hs++;
         cyc();
      end
      i_wr_valid = 1'b0;
      chk("handshakes", 32'(hs), 32'd16);
      cyc();
      chk("preview_full", o_data, 32'h30313233);

      // Lockout during scroll, then asynchronous reset mid-scroll
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      i_wr_valid = 1'b1;
      i_wr_data  = "Z";
      for (int i = 0; i < 12; i++) begin
         i_start = (i == 6);
         cyc();
      end
      i_start = 1'b0;
      i_wr_valid = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      async_reset();
      cyc();

      // Loop and abort with "12"
      put("1"); put("2");
      i_loop  = 1'b1;
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      for (int i = 1; i <= 26; i++) begin
         cyc();
         if (i == 21) chk("loop_blank", o_data, 32'h00000000);
         if (i == 25) chk("loop_wrap", o_data, 32'h00000031);
      end
      i_stop = 1'b1;
      cyc();
      i_stop = 1'b0;
      chk("stop_busy", 32'(o_busy), 32'd0);
      chk("stop_done", 32'(o_done), 32'd0);
      cyc();
      chk("stop_preview", o_data, 32'h31320000);
      i_loop = 1'b0;

      // Collisions
      i_clear    = 1'b1;
      i_wr_valid = 1'b1;
      i_wr_data  = "7";
      cyc();
      i_clear    = 1'b0;
      i_wr_valid = 1'b0;
      cyc();
      chk("clear_wins", o_data, 32'h0);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("start_empty", 32'(o_busy), 32'd0);
      i_start    = 1'b1;
      i_wr_valid = 1'b1;
      i_wr_data  = "9";
      cyc();
      i_start    = 1'b0;
      i_wr_valid = 1'b0;
      chk("start_with_write", 32'(o_busy), 32'd1);
      cyc();
      chk("first_frame_9", o_data, 32'h00000039);
      for (int i = 0; i < 25; i++) cyc();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) begin
            async_reset();
         end
         i_wr_valid = ($urandom % 3) == 0;
         i_wr_data  = 8'(8'h20 + ($urandom % 95));
         i_clear    = ($urandom % 40) == 0;
         i_start    = ($urandom % 12) == 0;
         i_stop     = ($urandom % 150) == 0;
         if (($urandom % 200) == 0) i_loop = ~i_loop;
         cyc();
      end
      i_wr_valid = 1'b0;
      i_clear    = 1'b0;
      i_start    = 1'b0;
      i_stop     = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
